// File: rtl/alu_uart_interface_pkg.sv
// Shared encodings for the ALU/UART control stage: FSM states and ALU opcodes.
package alu_uart_interface_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_t;

  // ALU operation codes; the ALU model and the bench both read these.
  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundle of the UART receive/transmit handshakes and the ALU operand/result bus.
//
// Handshake rules:
//   rx_done  : one-cycle pulse; rx_data is valid in that cycle only. There is no
//              back-pressure, so a byte arriving while the stage is busy is dropped
//              and flagged by the sticky overrun output.
//   tx_start : one-cycle pulse with tx_data valid; it is only raised in a cycle
//              where tx_busy was sampled low (tx_busy acts as an inverted ready).
//   ALU      : operando_A/operando_B/cod_operacion are held registers; alu_result
//              is a purely combinational function of them.
interface alu_uart_interface_if #(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
);
  import alu_uart_interface_pkg::*;

  logic                 rx_done;
  logic [NBITS-1:0]     rx_data;
  logic [NBITS-1:0]     alu_result;
  logic                 tx_busy;
  logic [NBITS-1:0]     operando_A;
  logic [NBITS-1:0]     operando_B;
  logic [COD_OP-1:0]    cod_operacion;
  logic                 tx_start;
  logic [NBITS-1:0]     tx_data;
  logic                 overrun;
  logic [STATE_W-1:0]   state_dbg;

  // Control stage side.
  modport master (
    input  rx_done, rx_data, alu_result, tx_busy,
    output operando_A, operando_B, cod_operacion, tx_start, tx_data, overrun,
           state_dbg
  );

  // UART/ALU side.
  modport slave (
    output rx_done, rx_data, alu_result, tx_busy,
    input  operando_A, operando_B, cod_operacion, tx_start, tx_data, overrun,
           state_dbg
  );

endinterface

// File: rtl/alu_uart_interface.sv
// Control stage around a combinational ALU: collects A, B and opcode bytes from
// the UART receiver, captures the ALU result and hands it to the transmitter.
// NBITS must be >= COD_OP so the opcode fits in one received byte.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int NBITS  = 8,
  parameter int COD_OP = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_uart_interface_if.master  bus
);

  state_t              state_q,    state_d;
  logic [NBITS-1:0]    op_a_q,     op_a_d;
  logic [NBITS-1:0]    op_b_q,     op_b_d;
  logic [COD_OP-1:0]   cod_q,      cod_d;
  logic [NBITS-1:0]    result_q,   result_d;
  logic [NBITS-1:0]    tx_data_q,  tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                overrun_q,  overrun_d;

  // Next-state and datapath update; tx_start defaults low so it is always a single pulse.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cod_d      = cod_q;
    result_d   = result_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    case (state_q)
      WAIT_A: begin
        if (bus.rx_done) begin
          op_a_d  = bus.rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bus.rx_done) begin
          op_b_d  = bus.rx_data;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (bus.rx_done) begin
          cod_d   = bus.rx_data[COD_OP-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Operands settled at the previous edge, so the ALU output is valid now.
        result_d = bus.alu_result;
        state_d  = SEND;
        if (bus.rx_done) overrun_d = 1'b1;
      end
      SEND: begin
        if (bus.rx_done) overrun_d = 1'b1;
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = result_q;
          state_d    = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cod_q      <= '0;
      result_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cod_q      <= cod_d;
      result_q   <= result_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.operando_A    = op_a_q;
  assign bus.operando_B    = op_b_q;
  assign bus.cod_operacion = cod_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.overrun       = overrun_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface with a combinational ALU attached to its operand bus.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_uart_interface_if #(.NBITS(8), .COD_OP(6)) bus ();

  alu_uart_interface #(.NBITS(8), .COD_OP(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational ALU; undefined opcodes return all ones.
  always_comb begin
    case (bus.cod_operacion)
      ADD:     bus.alu_result = bus.operando_A + bus.operando_B;
      SUB:     bus.alu_result = bus.operando_A - bus.operando_B;
      AND:     bus.alu_result = bus.operando_A & bus.operando_B;
      OR:      bus.alu_result = bus.operando_A | bus.operando_B;
      XOR:     bus.alu_result = bus.operando_A ^ bus.operando_B;
      SRA:     bus.alu_result = $signed(bus.operando_A) >>> bus.operando_B;
      SRL:     bus.alu_result = bus.operando_A >> bus.operando_B;
      NOR:     bus.alu_result = ~(bus.operando_A | bus.operando_B);
      default: bus.alu_result = 8'hFF;
    endcase
  end

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one rx_done pulse carrying byte b, consumed at the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.state_dbg !== 3'd0) begin $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); failures++; end
    checks++;
    if ({bus.operando_A, bus.operando_B, bus.cod_operacion, bus.tx_data} !== 30'd0) begin
      $display("FAIL reset_regs got A=%h B=%h op=%h tx=%h exp all 0", bus.operando_A, bus.operando_B,
               bus.cod_operacion, bus.tx_data);
      failures++;
    end
    checks++;
    if ({bus.tx_start, bus.overrun} !== 2'b00) begin
      $display("FAIL reset_flags got start=%b ovr=%b exp 0 0", bus.tx_start, bus.overrun); failures++;
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_add();
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    checks++;
    if ({bus.operando_A, bus.operando_B} !== 16'h0503) begin
      $display("FAIL add_operands got A=%h B=%h exp 05 03", bus.operando_A, bus.operando_B); failures++;
    end
    checks++;
    if (bus.cod_operacion !== 6'h20) begin $display("FAIL add_opcode got=%h exp=20", bus.cod_operacion); failures++; end
    cycle(); // E1: result captured
    checks++;
    if (bus.tx_start !== 1'b0) begin $display("FAIL add_early_start got=%b exp=0", bus.tx_start); failures++; end
    cycle(); // E2: pulse
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h08) begin
      $display("FAIL add_pulse got start=%b data=%h exp 1 08", bus.tx_start, bus.tx_data); failures++;
    end
    cycle(); // E3: pulse falls
    checks++;
    if (bus.tx_start !== 1'b0) begin $display("FAIL add_pulse_width got=%b exp=0", bus.tx_start); failures++; end
  endtask

  task automatic test_sub_negative();
    send_byte(8'h03); send_byte(8'h05); send_byte(8'h22);
    cycle(); cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hFE) begin
      $display("FAIL sub_pulse got start=%b data=%h exp 1 fe", bus.tx_start, bus.tx_data); failures++;
    end
    checks++;
    if (bus.state_dbg !== 3'd0) begin $display("FAIL sub_state got=%0d exp=0", bus.state_dbg); failures++; end
    cycle();
  endtask

  task automatic test_tx_busy();
    int early;
    early = 0;
    bus.tx_busy = 1'b1;
    send_byte(8'h10); send_byte(8'h01); send_byte(8'h20);
    cycle(); // now in SEND
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (bus.tx_start !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin $display("FAIL busy_hold got pulses=%0d exp=0", early); failures++; end
    checks++;
    if (bus.state_dbg !== 3'd4) begin $display("FAIL busy_state got=%0d exp=4", bus.state_dbg); failures++; end
    bus.tx_busy = 1'b0;
    cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h11) begin
      $display("FAIL busy_pulse got start=%b data=%h exp 1 11", bus.tx_start, bus.tx_data); failures++;
    end
    cycle();
    checks++;
    if (bus.tx_start !== 1'b0) begin $display("FAIL busy_pulse_width got=%b exp=0", bus.tx_start); failures++; end
  endtask

  task automatic test_overrun();
    send_byte(8'h07); send_byte(8'h01); send_byte(8'h20);
    // Stray byte lands while the FSM is in EXEC.
    bus.rx_done = 1'b1;
    bus.rx_data = 8'hAA;
    cycle();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    checks++;
    if (bus.overrun !== 1'b1 || bus.state_dbg !== 3'd4) begin
      $display("FAIL ovr_flag got ovr=%b state=%0d exp 1 4", bus.overrun, bus.state_dbg); failures++;
    end
    cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h08) begin
      $display("FAIL ovr_pulse got start=%b data=%h exp 1 08", bus.tx_start, bus.tx_data); failures++;
    end
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h20);
    cycle(); cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h02 || bus.overrun !== 1'b1) begin
      $display("FAIL ovr_next got start=%b data=%h ovr=%b exp 1 02 1", bus.tx_start, bus.tx_data, bus.overrun);
      failures++;
    end
    cycle();
  endtask

  task automatic test_undefined_opcode();
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h3F);
    cycle(); cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hFF) begin
      $display("FAIL undef_pulse got start=%b data=%h exp 1 ff", bus.tx_start, bus.tx_data); failures++;
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hE0);
    checks++;
    if (bus.cod_operacion !== 6'h20) begin $display("FAIL opcode_trunc got=%h exp=20", bus.cod_operacion); failures++; end
    cycle(); cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h03) begin
      $display("FAIL trunc_pulse got start=%b data=%h exp 1 03", bus.tx_start, bus.tx_data); failures++;
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h55);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state_dbg !== 3'd0 || bus.operando_A !== 8'h00 || bus.tx_data !== 8'h00 ||
        bus.tx_start !== 1'b0 || bus.overrun !== 1'b0 || bus.cod_operacion !== 6'h00) begin
      $display("FAIL mid_reset got state=%0d A=%h op=%h tx=%h start=%b ovr=%b exp all 0", bus.state_dbg,
               bus.operando_A, bus.cod_operacion, bus.tx_data, bus.tx_start, bus.overrun);
      failures++;
    end
    cycle();
    rst_n = 1'b1;
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h24);
    checks++;
    if ({bus.operando_A, bus.operando_B} !== 16'h0202) begin
      $display("FAIL post_reset_operands got A=%h B=%h exp 02 02", bus.operando_A, bus.operando_B); failures++;
    end
    cycle(); cycle();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h02) begin
      $display("FAIL post_reset_pulse got start=%b data=%h exp 1 02", bus.tx_start, bus.tx_data); failures++;
    end
    cycle();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.tx_busy = 1'b0;
    test_reset();
    test_add();
    test_sub_negative();
    test_tx_busy();
    test_overrun();
    test_undefined_opcode();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Control stage directly upstream and downstream of the ALU.
- Collects three bytes from the UART receiver: operand A, operand B, then the operation code.
- Drives the ALU operand and operation inputs, captures the ALU result and hands it to the UART transmitter with a start pulse.
- Sequential FSM with a single clock domain; the ALU itself stays purely combinational.

Parameters:
- NBITS, 8, data width of operands, result and UART byte.
- COD_OP, 6, operation-code width; NBITS >= COD_OP is required.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_done  in  1  one-cycle pulse: rx_data is valid.
- rx_data  in  NBITS  received byte.
- alu_result  in  NBITS  ALU output (combinational from the ports below).
- tx_busy  in  1  transmitter busy; tx_start is not allowed while high.
- operando_A  out  NBITS  registered operand A to the ALU.
- operando_B  out  NBITS  registered operand B to the ALU.
- cod_operacion  out  COD_OP  registered operation code to the ALU.
- tx_start  out  1  registered one-cycle start pulse to the transmitter.
- tx_data  out  NBITS  registered byte to transmit.
- overrun  out  1  sticky: a byte was received while not accepting.

Behaviour:
- Reset (async assert, sync release):
  - state=WAIT_A.
  - operando_A, operando_B, cod_operacion, tx_data, result register = 0.
  - tx_start=0, overrun=0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- Transitions:
  - WAIT_A: rx_done=1 -> operando_A<=rx_data, go WAIT_B.
  - WAIT_B: rx_done=1 -> operando_B<=rx_data, go WAIT_OP.
  - WAIT_OP: rx_done=1 -> cod_operacion<=rx_data[COD_OP-1:0] (upper bits ignored), go EXEC.
  - EXEC: exactly one cycle; result register <= alu_result; go SEND.
  - SEND, tx_busy=1: stay; tx_start=0.
  - SEND, tx_busy=0: tx_start<=1, tx_data<=result register, go WAIT_A.
- tx_start is high for exactly one cycle and falls on the following edge in every case.
- Latency: opcode accepted at edge E0 -> result captured at E1 -> tx_start high from E2 to E3 when tx_busy=0 at E2. Each cycle of tx_busy=1 in SEND adds one cycle.
- Operand and opcode registers hold their value until overwritten by the next transaction. The ALU output therefore stays stable through SEND.
- rx_done while in EXEC or SEND: byte discarded, overrun<=1, state unaffected. overrun clears only on reset.
- rx_done in a WAIT state is always consumed; no byte is ever lost there.
- tx_busy is don't-care outside SEND.
- Unknown opcodes are not filtered; whatever the ALU returns (all ones for undefined codes) is transmitted.
- Reset asserted mid-transaction (any state) aborts immediately: no tx_start is emitted and partial operands are cleared.
- No timeout: a partial transaction waits indefinitely for the next byte.

Decomposition:
- Shared package holds:
  - state encoding constants (3-bit: WAIT_A=0 .. SEND=4);
  - operation-code constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111, so the ALU and the bench use one source.
- No sub-module: a single FSM plus a datapath register file. The top level of the bench instantiates this block together with the ALU.

Test Plan:
- ADD: bytes 0x05, 0x03, 0x20 with tx_busy=0 -> operando_A=0x05, operando_B=0x03, cod_operacion=0x20; one tx_start pulse two cycles after the opcode edge; tx_data=0x08.
- SUB negative: bytes 0x03, 0x05, 0x22 -> tx_data=0xFE; state returns to WAIT_A.
- Transmitter busy: ADD 0x10, 0x01 with tx_busy=1 for 5 cycles after EXEC -> tx_start stays 0 for those 5 cycles, then exactly one pulse with tx_data=0x11.
- Overrun: extra rx_done (0xAA) during EXEC or SEND -> overrun=1, byte ignored, tx_data unchanged. The next transaction 0x01, 0x01, 0x20 -> tx_data=0x02 and overrun stays 1.
- Undefined opcode: 0x0F, 0xF0, 0x3F -> tx_data=0xFF; byte 0xE0 as opcode -> cod_operacion=0x20 (upper bits dropped).
- Reset mid-operation: send 0x55 only, assert rst_n=0 asynchronously between edges -> all outputs 0 immediately. After release, 0x02, 0x02, 0x24 -> tx_data=0x02 with no stale-operand effect.
